// File: rtl/fifo_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx_pkg
// Description : Shared definitions for the FIFO-fed UART transmitter: state
//               encoding and default timing/width parameters. Kept separate
//               so a matching receiver can reuse the same encodings.
// Contents    : tx_state_e          - transmitter state encoding (3 bits)
//               DEFAULT_CLKS_PER_BIT - 100 MHz / 115200 baud
//               DEFAULT_WIDTH        - default FIFO word width
//               BITS_PER_BYTE        - data bits per UART frame
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_uart_tx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DEFAULT_WIDTH        = 24;
  localparam int BITS_PER_BYTE        = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/fifo_uart_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Baud-rate divider. Counts CLKS_PER_BIT cycles and pulses
//               bit_done on the last cycle of every bit period. Holding
//               restart high parks the count at zero so the first bit after
//               restart is a full period long.
// Ports       : clk      in  system clock
//               rst      in  asynchronous active-low reset
//               restart  in  hold count at zero (no bit_done while high)
//               bit_done out one-cycle pulse ending each bit period
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_done
);

  localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Wraps at every bit boundary, so there is no accumulated drift from one
  // bit (or byte) to the next.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_done = !restart && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : Pulls one word at a time from an upstream synchronous FIFO
//               and transmits it as WIDTH/8 bytes of 8N1 UART, least
//               significant byte and bit first.
// Ports       : clk   in  system clock (rising edge)
//               rst   in  asynchronous active-low reset
//               empty in  FIFO empty flag (sampled only while idle)
//               din   in  FIFO read data, valid the cycle after rd
//               rd    out FIFO read strobe, single-cycle registered pulse
//               txd   out UART line, idles high
//               busy  out high from the rd pulse to the end of the last stop
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             empty,
  input  logic [WIDTH-1:0] din,
  output logic             rd,
  output logic             txd,
  output logic             busy
);

  localparam int               BYTES     = WIDTH / BITS_PER_BYTE;
  localparam int               BCNT_W    = $clog2(BYTES + 1);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);

  tx_state_e         state_q,    state_d;
  logic [WIDTH-1:0]  shreg_q,    shreg_d;
  logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [2:0]        bit_cnt_q,  bit_cnt_d;
  logic              rd_q,       rd_d;
  logic              txd_q,      txd_d;
  logic              busy_q,     busy_d;

  logic [7:0] cur_byte;
  logic [2:0] next_bit;
  logic       restart;
  logic       bit_done;

  // The timer is held at zero until the first start bit, so START always
  // begins on a fresh bit period.
  assign restart  = (state_q == ST_IDLE) || (state_q == ST_FETCH) || (state_q == ST_LOAD);
  assign cur_byte = shreg_q[7:0];
  assign next_bit = bit_cnt_q + 3'd1;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .bit_done (bit_done)
  );

  // All outputs are computed for the next state, so rd/txd/busy come
  // straight from flops and change only on clock edges (or reset).
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    rd_d       = 1'b0;
    txd_d      = txd_q;
    busy_d     = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (!empty) begin
          state_d = ST_FETCH;
          rd_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end

      // rd is high during this state; FIFO data appears on din next cycle.
      ST_FETCH: begin
        state_d = ST_LOAD;
      end

      ST_LOAD: begin
        shreg_d    = din;
        byte_cnt_d = '0;
        bit_cnt_d  = '0;
        txd_d      = 1'b0;
        state_d    = ST_START;
      end

      ST_START: begin
        if (bit_done) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          txd_d     = cur_byte[0];
        end
      end

      ST_DATA: begin
        if (bit_done) begin
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_cnt_d = next_bit;
            txd_d     = cur_byte[next_bit];
          end
        end
      end

      ST_STOP: begin
        if (bit_done) begin
          shreg_d    = shreg_q >> BITS_PER_BYTE;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            txd_d   = 1'b1;
          end else begin
            // Next start bit follows the stop bit with no idle gap.
            state_d = ST_START;
            txd_d   = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      rd_q       <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      rd_q       <= rd_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
    end
  end

  assign rd   = rd_q;
  assign txd  = txd_q;
  assign busy = busy_q;

endmodule
`default_nettype wire
